// File: rtl/cube_gen_if.sv
// Operand/result bundle for the pipelined cube generator.
// The master drives operands; the slave (cube_gen) returns results.
interface cube_gen_if #(
    parameter int N = 4
);
    logic           in_valid;
    logic [N-1:0]   num;
    logic           out_valid;
    logic [2*N-1:0] out;
    logic           ovf;

    modport master (
        output in_valid,
        output num,
        input  out_valid,
        input  out,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  num,
        output out_valid,
        output out,
        output ovf
    );
endinterface

// File: rtl/cube_gen.sv
// Two-stage pipelined unsigned cube generator: square, then square*num.
// Results wider than 2N bits are flagged and either wrapped or saturated.
module cube_gen #(
    parameter int N        = 4,
    parameter int SATURATE = 0
) (
    input  logic       clk,
    input  logic       rst,
    cube_gen_if.slave  bus
);
    localparam int W2 = 2 * N;
    localparam int W3 = 3 * N;
    localparam bit SAT = (SATURATE != 0);

    logic          r_v1;
    logic [W2-1:0] r_sq;
    logic [N-1:0]  r_num;

    logic          r_out_valid;
    logic [W2-1:0] r_out;
    logic          r_ovf;

    logic [W2-1:0] w_sq;
    logic [W3-1:0] w_full;
    logic          w_ovf;
    logic [W2-1:0] w_res;

    assign w_sq   = {{N{1'b0}}, bus.num} * {{N{1'b0}}, bus.num};
    assign w_full = {{N{1'b0}}, r_sq} * {{W2{1'b0}}, r_num};
    assign w_ovf  = |w_full[W3-1:W2];
    assign w_res  = (SAT && w_ovf) ? {W2{1'b1}} : w_full[W2-1:0];

    // Stage 1: operand data only moves on a valid beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1  <= 1'b0;
            r_sq  <= '0;
            r_num <= '0;
        end else begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_sq  <= w_sq;
                r_num <= bus.num;
            end
        end
    end

    // Stage 2: result holds its last value across bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_out_valid <= r_v1;
            if (r_v1) begin
                r_out <= w_res;
                r_ovf <= w_ovf;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;
    assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_cube_gen.sv
// Bench for cube_gen: wrap and saturate variants driven in lockstep,
// checked against a queue-based arithmetic reference model.
module tb_cube_gen;
    localparam int N   = 4;
    localparam int LIM = 1 << (2 * N);

    typedef struct {
        int due;
        int n;
    } item_t;

    logic clk;
    logic rst;

    cube_gen_if #(.N(N)) bus0 ();
    cube_gen_if #(.N(N)) bus1 ();

    cube_gen #(.N(N), .SATURATE(0)) u_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    cube_gen #(.N(N), .SATURATE(1)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int    checks;
    int    errors;
    int    edge_n;
    item_t q[$];
    int    last0;
    int    last1;
    int    lovf0;
    int    lovf1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        bus0.in_valid = v;
        bus1.in_valid = v;
        bus0.num      = N'(n);
        bus1.num      = N'(n);
    endtask

    // One clock: model samples at the edge, outputs compared at negedge
    task automatic step(input string tag);
        item_t e;
        int    cube;
        int    ov;
        @(posedge clk);
        edge_n++;
        if (!rst && bus0.in_valid)
            q.push_back('{due: edge_n + 1, n: int'(bus0.num)});
        @(negedge clk);
        if (q.size() > 0 && q[0].due == edge_n) begin
            e     = q.pop_front();
            cube  = e.n * e.n * e.n;
            ov    = (cube >= LIM) ? 1 : 0;
            last0 = cube % LIM;
            last1 = ov ? LIM - 1 : cube % LIM;
            lovf0 = ov;
            lovf1 = ov;
            check({tag, ".vld0"}, 32'(bus0.out_valid), 1);
            check({tag, ".vld1"}, 32'(bus1.out_valid), 1);
        end else begin
            check({tag, ".idle0"}, 32'(bus0.out_valid), 0);
            check({tag, ".idle1"}, 32'(bus1.out_valid), 0);
        end
        check({tag, ".out0"}, 32'(bus0.out), last0);
        check({tag, ".ovf0"}, 32'(bus0.ovf), lovf0);
        check({tag, ".out1"}, 32'(bus1.out), last1);
        check({tag, ".ovf1"}, 32'(bus1.ovf), lovf1);
    endtask

    task automatic flush(input string tag);
        drive(1'b0, 0);
        for (int i = 0; i < 3; i++) step(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        edge_n = 0;
        last0  = 0;
        last1  = 0;
        lovf0  = 0;
        lovf1  = 0;
        drive(1'b0, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst.vld0", 32'(bus0.out_valid), 0);
        check("rst.out0", 32'(bus0.out), 0);
        check("rst.ovf1", 32'(bus1.ovf), 0);
        rst = 1'b0;

        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, i);
            step("seq");
        end
        flush("seq");

        drive(1'b1, 7);  step("big");
        drive(1'b1, 15); step("big");
        drive(1'b1, 6);  step("big");
        drive(1'b1, 0);  step("big");
        flush("big");

        drive(1'b1, 3); step("gap");
        drive(1'b0, 0); step("gap");
        drive(1'b1, 5); step("gap");
        flush("gap");

        drive(1'b1, 9);  step("inflt");
        drive(1'b1, 10); step("inflt");
        drive(1'b1, 11);
        #1 rst = 1'b1;
        #1;
        check("arst.vld0", 32'(bus0.out_valid), 0);
        check("arst.out0", 32'(bus0.out), 0);
        check("arst.vld1", 32'(bus1.out_valid), 0);
        check("arst.out1", 32'(bus1.out), 0);
        q.delete();
        last0 = 0;
        last1 = 0;
        lovf0 = 0;
        lovf1 = 0;
        drive(1'b0, 0);
        step("inrst");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("nostale");

        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i);
            step("sweep");
        end
        flush("sweep");

        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(9, 0) < 7), int'($urandom_range(15, 0)));
            step("rand");
        end
        flush("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
